// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, state encoding and helpers for the dmem_hs
// data memory.
//   SIZE_*        request size codes carried on req_size
//   ST_*          FSM state codes, also visible on dbg_state
//   state_e       enum view of the same codes, for debug/assertion typing
//   misaligned()  1 when a size/low-address pair cannot be serviced
package dmem_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } state_e;

  // Reserved size is always an error; half needs even, word needs 4-aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] alo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = alo[0];
      SIZE_W:  bad = (alo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: combinational load formatter.
//   b0..b3   bytes m[a], m[a+1], m[a+2], m[a+3] (b0 is the most significant)
//   size     SIZE_B / SIZE_H / SIZE_W / SIZE_RSV
//   sgn      1 = sign-extend byte/half, 0 = zero-extend
//   alo      addr[1:0], used only to detect misalignment
//   data     32-bit right-justified result, 0 for any erroring access
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [7:0]  b0,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  input  logic [7:0]  b3,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  alo,
  output logic [31:0] data
);

  logic ext_bit;

  // The sign comes from the byte at addr for both byte and half (big-endian MSB).
  assign ext_bit = sgn & b0[7];

  always_comb begin
    data = 32'h0;
    if (!misaligned(size, alo)) begin
      case (size)
        SIZE_B:  data = {{24{ext_bit}}, b0};
        SIZE_H:  data = {{16{ext_bit}}, b0, b1};
        SIZE_W:  data = {b0, b1, b2, b3};
        default: data = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: big-endian byte-addressed data memory with valid/ready request and
// response channels, configurable wait states and one outstanding access.
//   DM_clk, DM_rst_n   clock / asynchronous active-low reset
//   req_*              request channel (req_ready high only in IDLE)
//   rsp_*              registered response channel, held until rsp_ready
//   dbg_state          current FSM state code (ST_* in dmem_pkg)
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; the sender keeps its payload stable while valid is high and not yet
// accepted, and ready may depend combinationally only on the receiver's state.
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int    ADDR_W      = 11,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              DM_clk,
  input  logic              DM_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        dbg_state
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [7:0]        mem [DEPTH];

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              h_we;
  logic [1:0]        h_size;
  logic              h_signed;
  logic [ADDR_W-1:0] h_addr;
  logic [31:0]       h_wdata;

  logic              rsp_valid_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [ADDR_W-1:0] a1, a2, a3;
  logic              h_bad;
  logic [31:0]       load_data;

  // Aligned accesses never cross the top of the array, so wrapping here only
  // matters for bytes that the formatter ignores.
  assign a1    = h_addr + ADDR_W'(1);
  assign a2    = h_addr + ADDR_W'(2);
  assign a3    = h_addr + ADDR_W'(3);
  assign h_bad = misaligned(h_size, h_addr[1:0]);

  dmem_load_ext u_ext (
    .b0   (mem[h_addr]),
    .b1   (mem[a1]),
    .b2   (mem[a2]),
    .b3   (mem[a3]),
    .size (h_size),
    .sgn  (h_signed),
    .alo  (h_addr[1:0]),
    .data (load_data)
  );

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state;

  always_ff @(posedge DM_clk or negedge DM_rst_n) begin
    if (!DM_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      h_we        <= 1'b0;
      h_size      <= SIZE_B;
      h_signed    <= 1'b0;
      h_addr      <= '0;
      h_wdata     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            h_we     <= req_we;
            h_size   <= req_size;
            h_signed <= req_signed;
            h_addr   <= req_addr;
            h_wdata  <= req_wdata;
            if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_EXEC;
          else             cnt   <= cnt - 4'd1;
        end
        ST_EXEC: begin
          rdata_q     <= h_we ? 32'h0 : load_data;
          err_q       <= h_bad;
          rsp_valid_q <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The array has no reset; a store lands only from EXEC, so a reset taken
  // before EXEC drops it and one taken afterwards leaves it in place.
  always_ff @(posedge DM_clk) begin
    if (state == ST_EXEC && h_we && !h_bad) begin
      case (h_size)
        SIZE_B: mem[h_addr] <= h_wdata[7:0];
        SIZE_H: begin
          mem[h_addr] <= h_wdata[15:8];
          mem[a1]     <= h_wdata[7:0];
        end
        SIZE_W: begin
          mem[h_addr] <= h_wdata[31:24];
          mem[a1]     <= h_wdata[23:16];
          mem[a2]     <= h_wdata[15:8];
          mem[a3]     <= h_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
module tb_dmem_hs;
  import dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0_n = 1'b0;
  logic rst3_n = 1'b0;

  // ---------------- shared request bus, routed by sel ----------------
  logic        sel = 1'b0;   // 0 -> u0 (WAIT_CYCLES=0), 1 -> u3 (WAIT_CYCLES=3)
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [10:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        rv0, rv3, rr0, rr3;
  logic        req_ready0, req_ready3, rsp_valid0, rsp_valid3, rsp_err0, rsp_err3;
  logic [31:0] rsp_rdata0, rsp_rdata3;
  logic [1:0]  dbg0, dbg3;

  assign rv0 = req_valid & ~sel;
  assign rv3 = req_valid & sel;
  assign rr0 = rsp_ready & ~sel;
  assign rr3 = rsp_ready & sel;

  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  logic [1:0]  m_dbg;
  assign m_req_ready = sel ? req_ready3 : req_ready0;
  assign m_rsp_valid = sel ? rsp_valid3 : rsp_valid0;
  assign m_rsp_err   = sel ? rsp_err3   : rsp_err0;
  assign m_rsp_rdata = sel ? rsp_rdata3 : rsp_rdata0;
  assign m_dbg       = sel ? dbg3       : dbg0;

  dmem_hs #(.ADDR_W(11), .WAIT_CYCLES(0)) u0 (
    .DM_clk(clk), .DM_rst_n(rst0_n),
    .req_valid(rv0), .req_ready(req_ready0), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rr0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .dbg_state(dbg0)
  );

  dmem_hs #(.ADDR_W(11), .WAIT_CYCLES(3)) u3 (
    .DM_clk(clk), .DM_rst_n(rst3_n),
    .req_valid(rv3), .req_ready(req_ready3), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rr3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .dbg_state(dbg3)
  );

  // ---------------- scoreboard / reference model ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0] refm [2][2048];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural view: an access touches 2**size consecutive bytes, MSB first.
  function automatic void model(input int s, input logic we, input logic [1:0] sz,
                                input logic sg, input int ad, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    n  = 1 << sz;
    er = (sz == 2'b11) || ((ad % n) != 0);
    rd = 32'h0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < n; i++)
        refm[s][(ad + i) % 2048] = 8'(wd >> (8 * (n - 1 - i)));
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(refm[s][ad + i]);
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start(input string tag, input logic we, input logic [1:0] sz,
                       input logic sg, input int ad, input logic [31:0] wd);
    @(negedge clk);
    check({tag, ".idle_ready"}, 32'(m_req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = 11'(ad);
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    // Scramble the payload: the holding registers must not follow it.
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = 11'($urandom);
    req_wdata  = $urandom;
  endtask

  task automatic wait_rsp(input string tag);
    int lat;
    logic rr_seen;
    lat = 0;
    rr_seen = 1'b0;
    while (!m_rsp_valid && lat < 40) begin
      if (m_req_ready) rr_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), sel ? 32'd4 : 32'd1);
    check({tag, ".busy_ready"}, 32'(rr_seen), 32'd0);
  endtask

  task automatic finish_rsp(input string tag, input logic [31:0] erd, input logic eer, input int stall);
    check({tag, ".rdata"}, m_rsp_rdata, erd);
    check({tag, ".err"}, 32'(m_rsp_err), 32'(eer));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 32'(m_rsp_valid), 32'd1);
      check({tag, ".hold_rdata"}, m_rsp_rdata, erd);
      check({tag, ".hold_ready"}, 32'(m_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(m_rsp_valid), 32'd0);
    check({tag, ".post_ready"}, 32'(m_req_ready), 32'd1);
  endtask

  task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                    input int ad, input logic [31:0] wd, input int stall,
                    input logic use_k, input logic [31:0] k_rd, input logic k_err);
    logic [31:0] erd;
    logic eer;
    model(int'(sel), we, sz, sg, ad, wd, erd, eer);
    if (use_k) begin
      erd = k_rd;
      eer = k_err;
    end
    start(tag, we, sz, sg, ad, wd);
    wait_rsp(tag);
    finish_rsp(tag, erd, eer, stall);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0]  sz;
    int          ad;
    logic [31:0] erd;
    logic        eer;

    // reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    check("rst.u0_valid", 32'(rsp_valid0), 32'd0);
    check("rst.u0_ready", 32'(req_ready0), 32'd1);
    check("rst.u0_rdata", rsp_rdata0, 32'd0);
    check("rst.u0_err",   32'(rsp_err0), 32'd0);
    check("rst.u3_valid", 32'(rsp_valid3), 32'd0);
    check("rst.u3_ready", 32'(req_ready3), 32'd1);
    check("rst.u0_state", 32'(dbg0), 32'(ST_IDLE));
    @(negedge clk);
    rst0_n = 1'b1;
    rst3_n = 1'b1;

    // fill u0 completely so every later load has a defined reference
    sel = 1'b0;
    for (int a = 0; a < 2048; a += 4)
      op("fill0", 1'b1, SIZE_W, 1'b0, a, $urandom, 0, 1'b0, 32'h0, 1'b0);

    // word store / loads with sign and zero extension
    op("st_w10",   1'b1, SIZE_W, 1'b0, 'h010, 32'hDEADBEEF, 0, 1'b1, 32'h0, 1'b0);
    op("ld_w10",   1'b0, SIZE_W, 1'b0, 'h010, 32'h0, 1, 1'b1, 32'hDEADBEEF, 1'b0);
    op("ld_b11u",  1'b0, SIZE_B, 1'b0, 'h011, 32'h0, 0, 1'b1, 32'h000000AD, 1'b0);
    op("ld_b12s",  1'b0, SIZE_B, 1'b1, 'h012, 32'h0, 0, 1'b1, 32'hFFFFFFBE, 1'b0);
    op("ld_h12s",  1'b0, SIZE_H, 1'b1, 'h012, 32'h0, 0, 1'b1, 32'hFFFFBEEF, 1'b0);
    op("ld_h12u",  1'b0, SIZE_H, 1'b0, 'h012, 32'h0, 0, 1'b1, 32'h0000BEEF, 1'b0);

    // top of the array
    op("st_h7fe",  1'b1, SIZE_H, 1'b0, 'h7FE, 32'hAAAA1234, 0, 1'b1, 32'h0, 1'b0);
    op("ld_b7fe",  1'b0, SIZE_B, 1'b0, 'h7FE, 32'h0, 0, 1'b1, 32'h00000012, 1'b0);
    op("ld_b7ff",  1'b0, SIZE_B, 1'b0, 'h7FF, 32'h0, 0, 1'b1, 32'h00000034, 1'b0);
    op("ld_h7fe",  1'b0, SIZE_H, 1'b0, 'h7FE, 32'h0, 0, 1'b1, 32'h00001234, 1'b0);

    // errors: no write, rdata 0
    op("ld_w13",   1'b0, SIZE_W, 1'b0, 'h013, 32'h0, 0, 1'b1, 32'h0, 1'b1);
    op("st_h05",   1'b1, SIZE_H, 1'b0, 'h005, 32'h5555, 0, 1'b1, 32'h0, 1'b1);
    op("ld_w04",   1'b0, SIZE_W, 1'b0, 'h004, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    op("st_rsv",   1'b1, SIZE_RSV, 1'b0, 'h010, 32'h11223344, 0, 1'b1, 32'h0, 1'b1);
    op("ld_rsv",   1'b0, SIZE_RSV, 1'b1, 'h010, 32'h0, 0, 1'b1, 32'h0, 1'b1);
    op("ld_w10b",  1'b0, SIZE_W, 1'b0, 'h010, 32'h0, 0, 1'b1, 32'hDEADBEEF, 1'b0);

    // reset mid-RESP after a committed store: outputs drop at once, data kept
    model(0, 1'b1, SIZE_W, 1'b0, 'h100, 32'hCAFEF00D, erd, eer);
    start("rst_resp", 1'b1, SIZE_W, 1'b0, 'h100, 32'hCAFEF00D);
    wait_rsp("rst_resp");
    #2;
    rst0_n = 1'b0;
    #1;
    check("rst_resp.valid", 32'(rsp_valid0), 32'd0);
    check("rst_resp.ready", 32'(req_ready0), 32'd1);
    check("rst_resp.state", 32'(dbg0), 32'(ST_IDLE));
    @(negedge clk);
    rst0_n = 1'b1;
    op("ld_after_rst", 1'b0, SIZE_W, 1'b0, 'h100, 32'h0, 0, 1'b1, 32'hCAFEF00D, 1'b0);

    // random traffic on u0
    for (int k = 0; k < 300; k++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom_range(0, 2047);
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) ad = ad & ~((1 << sz) - 1);
      op("rnd0", 1'($urandom), sz, 1'($urandom), ad, $urandom,
         $urandom_range(0, 2), 1'b0, 32'h0, 1'b0);
    end

    // u3: fill a small window, then wait-state timing
    sel = 1'b1;
    for (int a = 0; a < 64; a += 4)
      op("fill3", 1'b1, SIZE_W, 1'b0, a, $urandom, 0, 1'b0, 32'h0, 1'b0);
    op("w3_stall", 1'b0, SIZE_W, 1'b0, 'h008, 32'h0, 2, 1'b0, 32'h0, 1'b0);

    // reset during WAIT drops the pending store
    start("rst_wait", 1'b1, SIZE_W, 1'b0, 'h020, 32'h0BADF00D);
    check("rst_wait.in_wait", 32'(dbg3), 32'(ST_WAIT));
    rst3_n = 1'b0;
    #1;
    check("rst_wait.valid", 32'(rsp_valid3), 32'd0);
    check("rst_wait.ready", 32'(req_ready3), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst3_n = 1'b1;
    op("ld_w20", 1'b0, SIZE_W, 1'b0, 'h020, 32'h0, 0, 1'b0, 32'h0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom_range(0, 60);
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) ad = ad & ~((1 << sz) - 1);
      op("rnd3", 1'($urandom), sz, 1'($urandom), ad, $urandom,
         $urandom_range(0, 2), 1'b0, 32'h0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // absolute time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
